// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared FSM states, parity codes and stop-bit limits for the UART TX serializer
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // Out-of-range stop-bit counts fall back to the single-stop-bit frame.
    function automatic int legal_stop_bits(input int n);
        return (n >= STOP_BITS_MIN && n <= STOP_BITS_MAX) ? n : STOP_BITS_MIN;
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// rtl/uart_tx_shifter.sv - data shift register and bit counter for the UART TX serializer
module uart_tx_shifter #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    input  logic                  i_cnt_inc,
    output logic                  o_bit,
    output logic                  o_last
);

    localparam int              CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST_IDX = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CW-1:0]         r_bit_cnt;

    // r_bit_cnt is the index of the data bit currently on the line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_shreg   <= i_data;
            r_bit_cnt <= '0;
        end else begin
            if (i_shift) begin
                if (MSB_FIRST)
                    r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
                else
                    r_shreg <= {1'b0, r_shreg[DATA_WIDTH-1:1]};
            end
            if (i_cnt_inc && !o_last)
                r_bit_cnt <= r_bit_cnt + CW'(1);
        end
    end

    assign o_bit  = MSB_FIRST ? r_shreg[DATA_WIDTH-1] : r_shreg[0];
    assign o_last = (r_bit_cnt == LAST_IDX);

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// rtl/uart_tx_frame_serializer.sv - FSM-driven UART TX frame serializer with optional parity and 1/2 stop bits
module uart_tx_frame_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  bit_tick,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int   STOP_N    = legal_stop_bits(STOP_BITS);
    localparam logic STOP_LAST = 1'(STOP_N - 1);

    tx_state_t r_state, w_state_next;
    logic      r_tx_out, w_tx_next;
    logic      r_busy, w_busy_next;
    logic      r_frame_done, w_done_next;
    logic      r_par_en, r_parity;
    logic      r_stop_cnt;
    logic      w_load, w_shift, w_cnt_inc, w_stop_clr, w_stop_inc;
    logic      w_bit, w_last;

    uart_tx_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shifter (
        .CLK       (CLK),
        .RST       (RST),
        .i_load    (w_load),
        .i_data    (P_DATA),
        .i_shift   (w_shift),
        .i_cnt_inc (w_cnt_inc),
        .o_bit     (w_bit),
        .o_last    (w_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Every line transition happens on a bit_tick, so each bit lasts one full tick period.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx_out;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_cnt_inc    = 1'b0;
        w_stop_clr   = 1'b0;
        w_stop_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_next = 1'b1;
                if (Data_Valid) begin
                    w_state_next = ST_ARM;
                    w_busy_next  = 1'b1;
                    w_load       = 1'b1;
                end
            end
            ST_ARM: begin
                if (bit_tick) begin
                    w_state_next = ST_START;
                    w_tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    w_state_next = ST_DATA;
                    w_tx_next    = w_bit;
                    w_shift      = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (w_last) begin
                        if (r_par_en) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
                            w_stop_clr   = 1'b1;
                        end
                    end else begin
                        w_tx_next = w_bit;
                        w_shift   = 1'b1;
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    w_state_next = ST_STOP;
                    w_tx_next    = 1'b1;
                    w_stop_clr   = 1'b1;
                end
            end
            ST_STOP: begin
                w_tx_next = 1'b1;
                if (bit_tick) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        w_state_next = ST_IDLE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_stop_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tx_out     <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_par_en     <= 1'b0;
            r_parity     <= PAR_EVEN;
            r_stop_cnt   <= 1'b0;
        end else begin
            r_tx_out     <= w_tx_next;
            r_busy       <= w_busy_next;
            r_frame_done <= w_done_next;
            if (w_load) begin
                r_par_en <= PAR_EN;
                r_parity <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
            end
            if (w_load || w_stop_clr)
                r_stop_cnt <= 1'b0;
            else if (w_stop_inc)
                r_stop_cnt <= 1'b1;
        end
    end

    assign TX_OUT     = r_tx_out;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// tb/tb_uart_tx_frame_serializer.sv - directed self-checking bench for uart_tx_frame_serializer
module tb_uart_tx_frame_serializer;

    logic       CLK;
    logic       RST;
    logic [7:0] d8;
    logic [4:0] d5;
    logic       dv_a, dv_b, dv_c;
    logic       par_en, par_typ;
    logic       bit_tick;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;
    logic       tx_c, busy_c, done_c;

    int checks = 0;
    int errors = 0;
    int period = 4;
    int phase  = 0;

    // a: 8-bit LSB-first 1 stop; b: 8-bit MSB-first 2 stops; c: 5-bit LSB-first 1 stop
    uart_tx_frame_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .STOP_BITS(1)) u_dut_a (
        .CLK(CLK), .RST(RST), .P_DATA(d8), .Data_Valid(dv_a), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .bit_tick(bit_tick), .TX_OUT(tx_a), .busy(busy_a), .frame_done(done_a));

    uart_tx_frame_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .STOP_BITS(2)) u_dut_b (
        .CLK(CLK), .RST(RST), .P_DATA(d8), .Data_Valid(dv_b), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .bit_tick(bit_tick), .TX_OUT(tx_b), .busy(busy_b), .frame_done(done_b));

    uart_tx_frame_serializer #(.DATA_WIDTH(5), .MSB_FIRST(0), .STOP_BITS(1)) u_dut_c (
        .CLK(CLK), .RST(RST), .P_DATA(d5), .Data_Valid(dv_c), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .bit_tick(bit_tick), .TX_OUT(tx_c), .busy(busy_c), .frame_done(done_c));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic sel_tx(input int w);
        return (w == 0) ? tx_a : (w == 1) ? tx_b : tx_c;
    endfunction

    function automatic logic sel_done(input int w);
        return (w == 0) ? done_a : (w == 1) ? done_b : done_c;
    endfunction

    task automatic set_dv(input int w, input logic v);
        if (w == 0) dv_a = v;
        else if (w == 1) dv_b = v;
        else dv_c = v;
    endtask

    task automatic step();
        @(negedge CLK);
        phase    = (phase + 1 >= period) ? 0 : phase + 1;
        bit_tick = (phase == 0);
    endtask

    task automatic send(input int w);
        set_dv(w, 1'b1);
        step();
        set_dv(w, 1'b0);
    endtask

    // Samples the line right after each tick edge; seq holds bits in transmission order, first bit in the MSB.
    task automatic capture(input int w, input int nbits, input bit want_end, input int inject_at,
                           output logic [15:0] seq, output int lead, output int done_mid,
                           output bit end_done, output int cycles, output bit timed_out);
        int  n;
        int  guard;
        bit  was_tick;
        bit  got;
        bit  injected;
        bit  inj_clear;
        n = 0; seq = '0; lead = 0; done_mid = 0; end_done = 0; cycles = 0;
        timed_out = 0; injected = 0; inj_clear = 0;
        while (n < nbits && cycles < 200) begin
            if (inject_at >= 0 && n == inject_at && !injected) begin
                set_dv(w, 1'b1);
                d8 = 8'hFF;
                injected  = 1;
                inj_clear = 1;
            end
            was_tick = bit_tick;
            step();
            cycles++;
            if (inj_clear) begin
                set_dv(w, 1'b0);
                inj_clear = 0;
            end
            if (sel_done(w)) done_mid++;
            if (was_tick) begin
                if (n == 0 && sel_tx(w) === 1'b1) lead++;
                else begin
                    seq = {seq[14:0], sel_tx(w)};
                    n++;
                end
            end
        end
        if (n < nbits) timed_out = 1;
        if (want_end && !timed_out) begin
            got = 0; guard = 0;
            while (!got && guard < 50) begin
                was_tick = bit_tick;
                step();
                guard++;
                if (was_tick) begin
                    got = 1;
                    end_done = sel_done(w);
                end else if (sel_done(w)) done_mid++;
            end
            if (!got) timed_out = 1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; dv_a = 0; dv_b = 0; dv_c = 0; d8 = '0; d5 = '0;
        par_en = 0; par_typ = 0; bit_tick = 0;
        repeat (3) step();
        checks++;
        if ({tx_a, busy_a, done_a} !== 3'b100)
            begin errors++; $display("FAIL reset_a: got %b expected 100", {tx_a, busy_a, done_a}); end
        checks++;
        if ({tx_b, busy_b, done_b} !== 3'b100)
            begin errors++; $display("FAIL reset_b: got %b expected 100", {tx_b, busy_b, done_b}); end
        checks++;
        if ({tx_c, busy_c, done_c} !== 3'b100)
            begin errors++; $display("FAIL reset_c: got %b expected 100", {tx_c, busy_c, done_c}); end
        RST = 1'b1;
        step();
    endtask

    task automatic test_lsb_no_parity();
        logic [15:0] seq; int lead, dm, cyc; bit ed, to;
        d8 = 8'hA5; par_en = 0; par_typ = 0;
        send(0);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL lsb_busy_rise: got %b expected 1", busy_a); end
        capture(0, 10, 1, -1, seq, lead, dm, ed, cyc, to);
        checks++;
        if (to) begin errors++; $display("FAIL lsb_timeout: got timeout expected frame"); end
        checks++;
        if (seq[9:0] !== 10'b0101001011)
            begin errors++; $display("FAIL lsb_seq: got %b expected 0101001011", seq[9:0]); end
        checks++;
        if (dm !== 0 || ed !== 1'b1)
            begin errors++; $display("FAIL lsb_frame_done: got early=%0d end=%b expected early=0 end=1", dm, ed); end
        step();
        checks++;
        if ({busy_a, tx_a} !== 2'b01)
            begin errors++; $display("FAIL lsb_busy_fall: got %b expected 01", {busy_a, tx_a}); end
    endtask

    task automatic test_parity();
        logic [15:0] seq; int lead, dm, cyc; bit ed, to;
        logic [10:0] exp;
        for (int typ = 0; typ < 2; typ++) begin
            d8 = 8'hA5; par_en = 1; par_typ = typ[0];
            send(0);
            d8 = 8'h00; par_en = 0; par_typ = ~typ[0];
            exp = (typ == 0) ? 11'b01010010101 : 11'b01010010111;
            capture(0, 11, 1, -1, seq, lead, dm, ed, cyc, to);
            checks++;
            if (to || seq[10:0] !== exp)
                begin errors++; $display("FAIL parity_seq typ=%0d: got %b expected %b", typ, seq[10:0], exp); end
            checks++;
            if (dm !== 0 || ed !== 1'b1)
                begin errors++; $display("FAIL parity_done typ=%0d: got early=%0d end=%b expected early=0 end=1", typ, dm, ed); end
            step();
        end
    endtask

    task automatic test_msb_two_stop();
        logic [15:0] seq; int lead, dm, cyc; bit ed, to;
        d8 = 8'h81; par_en = 0; par_typ = 0;
        send(1);
        checks++;
        if (busy_b !== 1'b1) begin errors++; $display("FAIL msb_busy_rise: got %b expected 1", busy_b); end
        capture(1, 11, 1, -1, seq, lead, dm, ed, cyc, to);
        checks++;
        if (to || seq[10:0] !== 11'b01000000111)
            begin errors++; $display("FAIL msb_seq: got %b expected 01000000111", seq[10:0]); end
        checks++;
        if (dm !== 0 || ed !== 1'b1)
            begin errors++; $display("FAIL msb_done_after_stop2: got early=%0d end=%b expected early=0 end=1", dm, ed); end
        step();
        checks++;
        if (busy_b !== 1'b0) begin errors++; $display("FAIL msb_busy_fall: got %b expected 0", busy_b); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq; int lead, dm, cyc; bit ed, to;
        bit bad;
        d8 = 8'h3C; par_en = 0; par_typ = 0;
        send(0);
        capture(0, 10, 1, 3, seq, lead, dm, ed, cyc, to);
        checks++;
        if (to || seq[9:0] !== 10'b0001111001)
            begin errors++; $display("FAIL b2b_first_seq: got %b expected 0001111001", seq[9:0]); end
        checks++;
        if (ed !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", ed); end
        step();
        d8 = 8'hC3;
        send(0);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", busy_a); end
        capture(0, 10, 1, -1, seq, lead, dm, ed, cyc, to);
        checks++;
        if (to || seq[9:0] !== 10'b0110000111)
            begin errors++; $display("FAIL b2b_second_seq: got %b expected 0110000111", seq[9:0]); end
        checks++;
        if (lead !== 0) begin errors++; $display("FAIL b2b_arm_align: got %0d idle ticks expected 0", lead); end
        bad = 0;
        repeat (12) begin
            step();
            if (busy_a !== 1'b0 || tx_a !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL b2b_no_extra_frame: got activity expected idle"); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] seq; int lead, dm, cyc; bit ed, to;
        d8 = 8'hA5; par_en = 0; par_typ = 0;
        send(0);
        capture(0, 5, 0, -1, seq, lead, dm, ed, cyc, to);
        checks++;
        if (to || seq[4:0] !== 5'b01010 || tx_a !== 1'b0)
            begin errors++; $display("FAIL rst_pre_bit3: got %b tx=%b expected 01010 tx=0", seq[4:0], tx_a); end
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({tx_a, busy_a, done_a} !== 3'b100)
            begin errors++; $display("FAIL rst_async: got %b expected 100", {tx_a, busy_a, done_a}); end
        step();
        step();
        RST = 1'b1;
        step();
        d8 = 8'h55;
        send(0);
        capture(0, 10, 1, -1, seq, lead, dm, ed, cyc, to);
        checks++;
        if (to || seq[9:0] !== 10'b0101010101)
            begin errors++; $display("FAIL rst_after_seq: got %b expected 0101010101", seq[9:0]); end
        checks++;
        if (dm !== 0 || ed !== 1'b1)
            begin errors++; $display("FAIL rst_after_done: got early=%0d end=%b expected early=0 end=1", dm, ed); end
        step();
    endtask

    task automatic test_narrow_constant_tick();
        logic [15:0] seq; int lead, dm, cyc; bit ed, to;
        bit bad;
        period = 1; phase = 0;
        bad = 0;
        repeat (10) begin
            step();
            if ({tx_c, busy_c, done_c} !== 3'b100) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL tick_in_idle: got activity expected idle"); end
        d5 = 5'h13;
        send(2);
        capture(2, 7, 1, -1, seq, lead, dm, ed, cyc, to);
        checks++;
        if (to || seq[6:0] !== 7'b0110011)
            begin errors++; $display("FAIL narrow_seq: got %b expected 0110011", seq[6:0]); end
        checks++;
        if (cyc !== 7 || lead !== 0)
            begin errors++; $display("FAIL narrow_one_bit_per_clk: got %0d cycles lead=%0d expected 7 lead=0", cyc, lead); end
        checks++;
        if (dm !== 0 || ed !== 1'b1)
            begin errors++; $display("FAIL narrow_done: got early=%0d end=%b expected early=0 end=1", dm, ed); end
        step();
        checks++;
        if (busy_c !== 1'b0) begin errors++; $display("FAIL narrow_busy_fall: got %b expected 0", busy_c); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lsb_no_parity();
        test_parity();
        test_msb_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_narrow_constant_tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
